// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sequences a shared clock-gate enable with wake latency and idle hysteresis
module clk_gate_ctrl #(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               force_on_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               ena_o,
  output logic [1:0]         state_o
);
  localparam int MAX_CNT = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int CW = $clog2(MAX_CNT + 1);
  typedef enum logic [1:0] {OFF = 2'd0, WAKE = 2'd1, ON = 2'd2, IDLE = 2'd3} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_ack;
  logic r_ena;
  logic w_any_req;
  assign w_any_req = |req_i | force_on_i;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      OFF: if (w_any_req) begin
        w_state_nxt = WAKE;
        w_cnt_nxt   = CW'(WAKE_CYCLES - 1);
      end
      WAKE: begin
        w_state_nxt = (r_cnt == '0) ? ON : WAKE;
        w_cnt_nxt   = (r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
      end
      ON: if (!w_any_req) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = CW'(IDLE_CYCLES - 1);
      end
      IDLE: begin
        w_state_nxt = w_any_req ? ON : ((r_cnt == '0) ? OFF : IDLE);
        w_cnt_nxt   = (w_any_req || r_cnt == '0) ? r_cnt : r_cnt - 1'b1;
      end
      default: w_state_nxt = OFF;
    endcase
  end
  // Outputs are driven from the next state so ack/ena line up with the FSM edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_ena   <= 1'b0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ena   <= (w_state_nxt != OFF);
      r_ack   <= req_i & {NUM_REQ{w_state_nxt == ON}};
    end
  end
  assign ack_o   = r_ack;
  assign ena_o   = r_ena;
  assign state_o = r_state;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed self-checking bench for clk_gate_ctrl (NUM_REQ=4, WAKE=2, IDLE=16)
module tb_clk_gate_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] req_i = '0;
  logic       force_on_i = 1'b0;
  logic [3:0] ack_o;
  logic       ena_o;
  logic [1:0] state_o;
  int n_pass = 0;
  int n_total = 0;
  clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(2), .IDLE_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .force_on_i(force_on_i),
    .ack_o(ack_o), .ena_o(ena_o), .state_o(state_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask
  task automatic test_reset();
    rst_i = 1'b1;
    step();
    chk("reset_state", {2'b0, state_o}, 4'd0);
    chk("reset_ena", {3'b0, ena_o}, 4'd0);
    chk("reset_ack", ack_o, 4'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_off_state", {2'b0, state_o}, 4'd0);
      chk("idle_off_ena", {3'b0, ena_o}, 4'd0);
      chk("idle_off_ack", ack_o, 4'd0);
    end
  endtask
  task automatic test_wake();
    req_i = 4'b0001;
    step();
    chk("wake_e0_state", {2'b0, state_o}, 4'd1);
    chk("wake_e0_ena", {3'b0, ena_o}, 4'd1);
    chk("wake_e0_ack", ack_o, 4'd0);
    step();
    chk("wake_e1_state", {2'b0, state_o}, 4'd1);
    chk("wake_e1_ack", ack_o, 4'd0);
    step();
    chk("wake_e2_state", {2'b0, state_o}, 4'd2);
    chk("wake_e2_ack", ack_o, 4'b0001);
    chk("wake_e2_ena", {3'b0, ena_o}, 4'd1);
  endtask
  task automatic test_idle_off();
    req_i = 4'b0000;
    step();
    chk("idle_k_state", {2'b0, state_o}, 4'd3);
    chk("idle_k_ack", ack_o, 4'd0);
    chk("idle_k_ena", {3'b0, ena_o}, 4'd1);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("idle_hold_ena", {3'b0, ena_o}, 4'd1);
      chk("idle_hold_state", {2'b0, state_o}, 4'd3);
    end
    step();
    chk("idle_end_ena", {3'b0, ena_o}, 4'd0);
    chk("idle_end_state", {2'b0, state_o}, 4'd0);
  endtask
  task automatic test_rerequest();
    req_i = 4'b0100;
    repeat (3) step();
    chk("rereq_on_ack", ack_o, 4'b0100);
    req_i = 4'b0000;
    step();
    chk("rereq_idle_state", {2'b0, state_o}, 4'd3);
    chk("rereq_idle_ack", ack_o, 4'd0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rereq_wait_ena", {3'b0, ena_o}, 4'd1);
    end
    req_i = 4'b0100;
    step();
    chk("rereq_cnt5_state", {2'b0, state_o}, 4'd2);
    chk("rereq_cnt5_ack", ack_o, 4'b0100);
    chk("rereq_cnt5_ena", {3'b0, ena_o}, 4'd1);
    req_i = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("rereq_cnt0_wait_ena", {3'b0, ena_o}, 4'd1);
      chk("rereq_cnt0_wait_state", {2'b0, state_o}, 4'd3);
    end
    req_i = 4'b0100;
    step();
    chk("rereq_cnt0_state", {2'b0, state_o}, 4'd2);
    chk("rereq_cnt0_ena", {3'b0, ena_o}, 4'd1);
    chk("rereq_cnt0_ack", ack_o, 4'b0100);
    req_i = 4'b0000;
    repeat (17) step();
    chk("rereq_final_state", {2'b0, state_o}, 4'd0);
  endtask
  task automatic test_force();
    force_on_i = 1'b1;
    step();
    chk("force_e0_state", {2'b0, state_o}, 4'd1);
    chk("force_e0_ena", {3'b0, ena_o}, 4'd1);
    step();
    step();
    chk("force_on_state", {2'b0, state_o}, 4'd2);
    chk("force_on_ack", ack_o, 4'd0);
    repeat (5) step();
    chk("force_hold_state", {2'b0, state_o}, 4'd2);
    chk("force_hold_ena", {3'b0, ena_o}, 4'd1);
    chk("force_hold_ack", ack_o, 4'd0);
    force_on_i = 1'b0;
    repeat (16) step();
    chk("force_drop_ena_hi", {3'b0, ena_o}, 4'd1);
    step();
    chk("force_drop_ena_lo", {3'b0, ena_o}, 4'd0);
    chk("force_drop_state", {2'b0, state_o}, 4'd0);
  endtask
  task automatic test_back_to_back();
    req_i = 4'b0011;
    repeat (3) step();
    chk("b2b_ack_both", ack_o, 4'b0011);
    req_i = 4'b1011;
    step();
    chk("b2b_late_join", ack_o, 4'b1011);
    req_i = 4'b0011;
    step();
    chk("b2b_late_drop", ack_o, 4'b0011);
    chk("b2b_state_on", {2'b0, state_o}, 4'd2);
  endtask
  task automatic test_reset_mid();
    rst_i = 1'b1;
    step();
    chk("rstmid_ena", {3'b0, ena_o}, 4'd0);
    chk("rstmid_ack", ack_o, 4'd0);
    chk("rstmid_state", {2'b0, state_o}, 4'd0);
    rst_i = 1'b0;
    step();
    chk("rewake_e0_state", {2'b0, state_o}, 4'd1);
    chk("rewake_e0_ack", ack_o, 4'd0);
    step();
    chk("rewake_e1_state", {2'b0, state_o}, 4'd1);
    chk("rewake_e1_ack", ack_o, 4'd0);
    step();
    chk("rewake_e2_state", {2'b0, state_o}, 4'd2);
    chk("rewake_e2_ack", ack_o, 4'b0011);
    req_i = 4'b0000;
  endtask
  initial begin
    test_reset();
    test_wake();
    test_idle_off();
    test_rerequest();
    test_force();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
